// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the alpha-compositing ASIP.
// Issues one outstanding imem request at a time and absorbs stall, redirect and HALT.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_INC    = 32'd4,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jmp_taken,
  input  logic [31:0] jmp_target,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        id_valid,
  output logic [1:0]  op,
  output logic [1:0]  inst,
  output logic        flagV,
  output logic [3:0]  R1_V1,
  output logic [3:0]  R2_V2_D,
  output logic [3:0]  R3_V3_D,
  output logic [26:0] Imme,
  output logic [31:0] curr_pc1,
  output logic        halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_SKID   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] skid_word;
  logic [31:0] ir;
  logic        load;
  logic [31:0] new_word;
  logic [31:0] pc_next;

  always_comb begin
    load     = !stall && ((state == S_REQ && imem_valid) || state == S_SKID);
    new_word = (state == S_SKID) ? skid_word : imem_rdata;
    pc_next  = pc + PC_INC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      skid_word  <= '0;
      ir         <= '0;
      curr_pc1   <= '0;
      id_valid   <= 1'b0;
    end else if (jmp_taken) begin
      ir        <= '0;
      curr_pc1  <= '0;
      id_valid  <= 1'b0;
      skid_word <= '0;
      pc        <= jmp_target;
      // A request still in flight must be drained at its old address before refetching.
      if (state == S_REQ && !imem_valid) begin
        state      <= S_DRAIN;
        drain_addr <= pc;
      end else if (state == S_DRAIN && !imem_valid) begin
        state <= S_DRAIN;
      end else begin
        state <= S_REQ;
      end
    end else if (load) begin
      ir       <= new_word;
      curr_pc1 <= pc_next;
      id_valid <= 1'b1;
      if (new_word == HALT_WORD) begin
        state <= S_HALTED;
      end else begin
        pc    <= pc_next;
        state <= S_REQ;
      end
    end else begin
      if (!stall) begin
        ir       <= '0;
        curr_pc1 <= '0;
        id_valid <= 1'b0;
      end
      case (state)
        S_IDLE:  state <= S_REQ;
        // Reaching here with a response means the stage is stalled: park it in the skid.
        S_REQ: begin
          if (imem_valid) begin
            skid_word <= imem_rdata;
            state     <= S_SKID;
          end
        end
        S_DRAIN: begin
          if (imem_valid) state <= S_REQ;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imem_rd   = (state == S_REQ) || (state == S_DRAIN);
    imem_addr = (state == S_DRAIN) ? drain_addr : pc;
    halted    = (state == S_HALTED);
    op        = ir[31:30];
    inst      = ir[29:28];
    flagV     = ir[27];
    R1_V1     = ir[26:23];
    R2_V2_D   = ir[22:19];
    R3_V3_D   = ir[18:15];
    Imme      = ir[26:0];
  end

endmodule
